// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: state numbers,
// opcode/funct values, ALU control codes and mux select encodings.
package mc_pkg;

    // Controller states (also exported on the debug state port)
    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXECUTE = 4'd6;
    localparam logic [3:0] ST_ALUWB   = 4'd7;
    localparam logic [3:0] ST_BEQ     = 4'd8;
    localparam logic [3:0] ST_ADDIEX  = 4'd9;
    localparam logic [3:0] ST_ADDIWB  = 4'd10;
    localparam logic [3:0] ST_JUMP    = 4'd11;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait MEM_LAT cycles for the synchronous memory
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class and R-type funct field to an ALU control
// code; funct_valid flags whether funct is one of the supported R-types.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    logic [2:0] funct_code;

    // Funct lookup, independent of aluop so DECODE can test legality
    always_comb begin
        funct_valid = 1'b1;
        funct_code  = ALU_ADD;
        case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_SLT:  funct_code = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    // Final selection by operation class; unused class falls back to add
    always_comb begin
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_code;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for a multi-cycle MIPS datapath. Memory-access states
// hold for MEM_LAT cycles so a registered-read block RAM fits in.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    logic [3:0] state_reg, state_next;
    logic [3:0] cnt_reg;
    logic       mem_last;
    logic       bad_decode;
    logic [1:0] aluop;
    logic [2:0] dec_alucontrol;
    logic       funct_valid;

    // Raw per-state strobes before stall/reset gating
    logic pcwrite_raw, branch_raw, irwrite_raw, memwrite_raw;
    logic regwrite_raw, done_raw, live;

    assign state    = state_reg;
    assign mem_last = (cnt_reg == LAST_CNT);
    assign live     = ena & ~rst;

    // ALU class depends only on registered state
    assign aluop = (state_reg == ST_EXECUTE) ? ALUOP_FUNCT :
                   (state_reg == ST_BEQ)     ? ALUOP_SUB   : ALUOP_ADD;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (dec_alucontrol),
        .funct_valid (funct_valid)
    );

    // Next-state selection; bad_decode marks an unsupported op/funct
    always_comb begin
        state_next = state_reg;
        bad_decode = 1'b0;
        case (state_reg)
            ST_FETCH:   if (mem_last) state_next = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            state_next = ST_EXECUTE;
                        end else begin
                            state_next = ST_FETCH;
                            bad_decode = 1'b1;
                        end
                    end
                    OP_BEQ:  state_next = ST_BEQ;
                    OP_ADDI: state_next = ST_ADDIEX;
                    OP_J:    state_next = ST_JUMP;
                    default: begin
                        state_next = ST_FETCH;
                        bad_decode = 1'b1;
                    end
                endcase
            end
            ST_MEMADR:  state_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   if (mem_last) state_next = ST_MEMWB;
            ST_MEMWR:   if (mem_last) state_next = ST_FETCH;
            ST_EXECUTE: state_next = ST_ALUWB;
            ST_ADDIEX:  state_next = ST_ADDIWB;
            default:    state_next = ST_FETCH;
        endcase
    end

    // State and wait counter; counter clears on any state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            cnt_reg   <= 4'd0;
        end else if (ena) begin
            if (state_next != state_reg) begin
                state_reg <= state_next;
                cnt_reg   <= 4'd0;
            end else if (is_mem_state(state_reg)) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    // Per-state selects and raw strobes; all zero while in reset
    always_comb begin
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_RT;
        pcsrc        = PCSRC_ALU;
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        done_raw     = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    alusrcb     = SRCB_FOUR;
                    irwrite_raw = mem_last;
                    pcwrite_raw = mem_last;
                end
                ST_DECODE:  alusrcb = SRCB_IMM_SH;
                ST_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                ST_MEMRD:   iord = 1'b1;
                ST_MEMWB: begin
                    memtoreg     = 1'b1;
                    regwrite_raw = 1'b1;
                    done_raw     = 1'b1;
                end
                ST_MEMWR: begin
                    iord         = 1'b1;
                    memwrite_raw = mem_last;
                    done_raw     = mem_last;
                end
                ST_EXECUTE: alusrca = 1'b1;
                ST_ALUWB: begin
                    regdst       = 1'b1;
                    regwrite_raw = 1'b1;
                    done_raw     = 1'b1;
                end
                ST_BEQ: begin
                    alusrca    = 1'b1;
                    branch_raw = 1'b1;
                    pcsrc      = PCSRC_ALUOUT;
                    done_raw   = 1'b1;
                end
                ST_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                ST_ADDIWB: begin
                    regwrite_raw = 1'b1;
                    done_raw     = 1'b1;
                end
                ST_JUMP: begin
                    pcsrc       = PCSRC_JUMP;
                    pcwrite_raw = 1'b1;
                    done_raw    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Enables and pulses are suppressed during stall or reset
    assign pcen       = live & (pcwrite_raw | (branch_raw & zero));
    assign irwrite    = live & irwrite_raw;
    assign memwrite   = live & memwrite_raw;
    assign regwrite   = live & regwrite_raw;
    assign instr_done = live & done_raw;
    assign illegal    = live & bad_decode;
    assign alucontrol = rst ? ALU_ADD : dec_alucontrol;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances (MEM_LAT 1,2,3) each run
// directed then random instructions, checked every cycle against a
// per-instruction cycle schedule built from the instruction semantics.
module tb_multicycle_controller;
    import mc_pkg::*;

    localparam int NI   = 3;
    localparam int NCYC = 3000;
    localparam int NDIR = 13;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwrite, branch, iord, irwrite, memwrite, regwrite;
        logic       regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alu;
        logic       done, illegal;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]      rst_a, ena_a, zero_a;
    logic [NI-1:0][5:0] op_a, funct_a;
    logic [NI-1:0]      pcen_w, iord_w, irwrite_w, memwrite_w, regwrite_w;
    logic [NI-1:0]      regdst_w, memtoreg_w, alusrca_w, done_w, illegal_w;
    logic [NI-1:0][1:0] alusrcb_w, pcsrc_w;
    logic [NI-1:0][2:0] alu_w;
    logic [NI-1:0][3:0] state_w;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            multicycle_controller #(.MEM_LAT(gi + 1)) dut (
                .clk(clk), .rst(rst_a[gi]), .ena(ena_a[gi]),
                .op(op_a[gi]), .funct(funct_a[gi]), .zero(zero_a[gi]),
                .pcen(pcen_w[gi]), .iord(iord_w[gi]), .irwrite(irwrite_w[gi]),
                .memwrite(memwrite_w[gi]), .regwrite(regwrite_w[gi]),
                .regdst(regdst_w[gi]), .memtoreg(memtoreg_w[gi]),
                .alusrca(alusrca_w[gi]), .alusrcb(alusrcb_w[gi]),
                .pcsrc(pcsrc_w[gi]), .alucontrol(alu_w[gi]),
                .instr_done(done_w[gi]), .illegal(illegal_w[gi]),
                .state(state_w[gi])
            );
        end
    endgenerate

    // Model: the expected cycle-by-cycle schedule of the current instruction
    cyc_t sched [NI][16];
    int   slen [NI];
    int   spos [NI];
    int   instr_idx [NI];
    bit   known [NI];
    int   first_done [NI];
    int   checks, errors;

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t r;
        r     = '0;
        r.st  = st;
        r.alu = 3'b010;
        return r;
    endfunction

    function automatic logic [2:0] fcode(input logic [5:0] f, output bit ok);
        ok = 1'b1;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin ok = 1'b0; return 3'b010; end
        endcase
    endfunction

    function automatic void push(input int i, input cyc_t r);
        sched[i][slen[i]] = r;
        slen[i]++;
    endfunction

    // Unroll one instruction into its per-cycle expected outputs
    function automatic void build(input int i, input logic [5:0] op,
                                  input logic [5:0] f, input int lat);
        cyc_t r;
        bit   fok;
        logic [2:0] fc;
        bit   legal;
        slen[i] = 0;
        spos[i] = 0;
        for (int k = 0; k < lat; k++) begin
            r = blank(0); r.alusrcb = 2'b01;
            if (k == lat - 1) begin r.irwrite = 1; r.pcwrite = 1; end
            push(i, r);
        end
        fc = fcode(f, fok);
        legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
                (op == 6'b001000) || (op == 6'b000010) || (op == 6'b000000 && fok);
        r = blank(1); r.alusrcb = 2'b11; r.illegal = !legal;
        push(i, r);
        if (!legal) return;
        if (op == 6'b100011 || op == 6'b101011) begin
            r = blank(2); r.alusrca = 1; r.alusrcb = 2'b10; push(i, r);
        end
        if (op == 6'b100011) begin
            for (int k = 0; k < lat; k++) begin
                r = blank(3); r.iord = 1; push(i, r);
            end
            r = blank(4); r.memtoreg = 1; r.regwrite = 1; r.done = 1; push(i, r);
        end else if (op == 6'b101011) begin
            for (int k = 0; k < lat; k++) begin
                r = blank(5); r.iord = 1;
                if (k == lat - 1) begin r.memwrite = 1; r.done = 1; end
                push(i, r);
            end
        end else if (op == 6'b000000) begin
            r = blank(6); r.alusrca = 1; r.alu = fc; push(i, r);
            r = blank(7); r.regdst = 1; r.regwrite = 1; r.done = 1; push(i, r);
        end else if (op == 6'b000100) begin
            r = blank(8); r.alusrca = 1; r.alu = 3'b110; r.branch = 1;
            r.pcsrc = 2'b01; r.done = 1; push(i, r);
        end else if (op == 6'b001000) begin
            r = blank(9); r.alusrca = 1; r.alusrcb = 2'b10; push(i, r);
            r = blank(10); r.regwrite = 1; r.done = 1; push(i, r);
        end else begin
            r = blank(11); r.pcsrc = 2'b10; r.pcwrite = 1; r.done = 1; push(i, r);
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Pick and start the next instruction for instance i
    task automatic start_instr(input int i);
        logic [5:0] op, f;
        int idx, r;
        logic [5:0] fl [5];
        fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
        fl[3] = 6'b100101; fl[4] = 6'b101010;
        idx = instr_idx[i];
        f = 6'($urandom_range(0, 63));
        if (idx == 0)      op = (i == 2) ? 6'b101011 : 6'b100011;
        else if (idx == 1) op = 6'b101011;
        else if (idx <= 3) op = 6'b000100;
        else if (idx <= 8) begin op = 6'b000000; f = fl[idx - 4]; end
        else if (idx == 9) begin op = 6'b000000; f = 6'b000111; end
        else if (idx == 10) op = 6'b001000;
        else if (idx == 11) op = 6'b000010;
        else if (idx == 12) op = 6'b111111;
        else begin
            r = $urandom_range(0, 7);
            case (r)
                0: op = 6'b100011; 1: op = 6'b101011; 2: op = 6'b000000;
                3: op = 6'b000100; 4: op = 6'b001000; 5: op = 6'b000010;
                6: op = 6'($urandom_range(0, 63));
                default: op = 6'b000000;
            endcase
            if ($urandom_range(0, 5) != 0) f = fl[$urandom_range(0, 4)];
        end
        op_a[i] = op;
        funct_a[i] = f;
        build(i, op, f, i + 1);
        instr_idx[i]++;
    endtask

    initial begin
        int   stall_left;
        bit   rst_fired;
        int   seq0 [6];
        logic [17:0] expv, gotv;
        cyc_t r;
        bit   live, rs, en, zr;
        int   cur, rel;
        checks = 0; errors = 0;
        stall_left = 5; rst_fired = 0;

        // Pin the model against hand-computed schedule lengths and fields
        build(0, 6'b100011, 6'b0, 1);      chk("model lw L1 len", slen[0], 5);
        build(0, 6'b101011, 6'b0, 3);      chk("model sw L3 len", slen[0], 8);
        chk("model sw memwrite pos", int'(sched[0][7].memwrite), 1);
        build(0, 6'b000000, 6'b101010, 2); chk("model slt len", slen[0], 5);
        chk("model slt alu", int'(sched[0][3].alu), 7);
        build(0, 6'b000100, 6'b0, 3);      chk("model beq L3 len", slen[0], 5);
        build(0, 6'b000000, 6'b000111, 1); chk("model bad funct len", slen[0], 2);
        chk("model bad funct illegal", int'(sched[0][1].illegal), 1);

        for (int i = 0; i < NI; i++) begin
            slen[i] = 0; spos[i] = 0; instr_idx[i] = 0;
            known[i] = 0; first_done[i] = 0;
        end
        for (int k = 0; k < 6; k++) seq0[k] = -1;

        @(posedge clk); #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            rel = cyc - 1;
            for (int i = 0; i < NI; i++) begin
                if (spos[i] >= slen[i]) start_instr(i);
                cur = instr_idx[i] - 1;
                r = sched[i][spos[i]];
                rs = (cyc < 2);
                en = 1'b1;
                zr = 1'($urandom_range(0, 1));
                if (cur == 2) zr = 1'b1;
                if (cur == 3) zr = 1'b0;
                if (i == 1 && cur == 0 && r.st == 4'd3 && stall_left > 0) begin
                    en = 1'b0; stall_left--;
                end
                if (i == 0 && cur == 4 && r.st == 4'd7 && !rst_fired) begin
                    rs = 1'b1; rst_fired = 1;
                end
                if (cur >= NDIR) begin
                    en = ($urandom_range(0, 5) != 0);
                    if ($urandom_range(0, 79) == 0) rs = 1'b1;
                end
                rst_a[i] = rs; ena_a[i] = en; zero_a[i] = zr;
            end

            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                r = sched[i][spos[i]];
                rs = rst_a[i]; en = ena_a[i]; zr = zero_a[i];
                live = en && !rs;
                expv = {live & (r.pcwrite | (r.branch & zr)),
                        rs ? 1'b0 : r.iord, live & r.irwrite, live & r.memwrite,
                        live & r.regwrite, rs ? 1'b0 : r.regdst,
                        rs ? 1'b0 : r.memtoreg, rs ? 1'b0 : r.alusrca,
                        rs ? 2'b00 : r.alusrcb, rs ? 2'b00 : r.pcsrc,
                        rs ? 3'b010 : r.alu, live & r.done, live & r.illegal};
                gotv = {pcen_w[i], iord_w[i], irwrite_w[i], memwrite_w[i],
                        regwrite_w[i], regdst_w[i], memtoreg_w[i], alusrca_w[i],
                        alusrcb_w[i], pcsrc_w[i], alu_w[i], done_w[i], illegal_w[i]};
                checks++;
                if (gotv !== expv) begin
                    errors++;
                    $display("FAIL outputs lat%0d cyc%0d st%0d got %b expected %b",
                             i + 1, cyc, r.st, gotv, expv);
                end
                if (known[i]) begin
                    checks++;
                    if (state_w[i] !== r.st) begin
                        errors++;
                        $display("FAIL state lat%0d cyc%0d got %0d expected %0d",
                                 i + 1, cyc, state_w[i], r.st);
                    end
                end
                if (i == 0 && rel >= 1 && rel <= 6) seq0[rel - 1] = int'(state_w[0]);
                if (cyc >= 2 && done_w[i] && first_done[i] == 0) first_done[i] = rel;
                if (rs) begin
                    spos[i] = 0;
                    known[i] = 1;
                end else if (en) begin
                    spos[i]++;
                end
            end
            @(posedge clk); #1;
        end

        // Hand-computed expectations from the directed opening instructions
        chk("lw L1 seq c1", seq0[0], 0);
        chk("lw L1 seq c2", seq0[1], 1);
        chk("lw L1 seq c3", seq0[2], 2);
        chk("lw L1 seq c4", seq0[3], 3);
        chk("lw L1 seq c5", seq0[4], 4);
        chk("lw L1 seq c6", seq0[5], 0);
        chk("lw L1 done cycle", first_done[0], 5);
        chk("lw L2 stalled done cycle", first_done[1], 12);
        chk("sw L3 done cycle", first_done[2], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style sequencer for a multi-cycle MIPS datapath: one shared ALU and one unified memory, driven over several states per instruction.
Decodes op/funct from the instruction register and drives every mux select and write enable per state.
Holds in the memory-access states for a fixed number of cycles so synchronous block RAM read latency is absorbed.
Sits alongside pc/top_memory and supersedes the single-cycle controller when the datapath runs multi-cycle.

Parameters:
MEM_LAT, 1, cycles spent in each memory-access state (FETCH, MEMRD, MEMWR); legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
ena  in  1  advance enable; 0 = stall
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
pcen  out  1  PC load = pcwrite | (branch & zero)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  out  1  instruction register load
memwrite  out  1  memory write enable
regwrite  out  1  register file write enable
regdst  out  1  write register: 0 = rt, 1 = rd
memtoreg  out  1  write data: 0 = ALUOut, 1 = memory data
alusrca  out  1  ALU A: 0 = PC, 1 = rs
alusrcb  out  2  ALU B: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2
pcsrc  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse when op/funct is unsupported
state  out  4  current state, for debug

Behaviour:
- Reset: synchronous, active-high.
  - state=FETCH (0), wait counter=0.
  - In every cycle where rst=1, all enables (pcen, irwrite, memwrite, regwrite), instr_done and illegal are 0; all selects are 0; alucontrol=010.
- States and outputs (anything not listed is 0; alucontrol defaults to 010):
  - FETCH: alusrcb=01. irwrite and pcwrite assert only on the cycle where cnt==MEM_LAT-1.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1. memwrite asserts only when cnt==MEM_LAT-1.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct.
  - ALUWB: regdst=1, regwrite=1.
  - BEQ: alusrca=1, alusrcb=00, alucontrol=110, branch=1, pcsrc=01.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH -> DECODE after MEM_LAT cycles.
  - DECODE, by op:
    - lw 100011 / sw 101011 -> MEMADR
    - 000000 -> EXECUTE
    - beq 000100 -> BEQ
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - anything else -> FETCH with illegal=1
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB after MEM_LAT cycles.
  - EXECUTE -> ALUWB. ADDIEX -> ADDIWB.
  - MEMWB, MEMWR (after MEM_LAT cycles), ALUWB, ADDIWB, BEQ, JUMP -> FETCH, with instr_done=1 on that final cycle.
- Funct decode:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct with op=000000: DECODE -> FETCH with illegal=1; no register write occurs.
- Wait counter: 4 bits; clears on every state change; increments only in memory states while ena=1.
- Latency in cycles (L = MEM_LAT): lw 3+2L, sw 2+2L, R-type L+3, addi L+3, beq L+2, j L+2.
- Stall (ena=0):
  - state and counter hold.
  - pcen, irwrite, memwrite, regwrite, instr_done and illegal are forced 0.
  - Selects and alucontrol still reflect the held state.
- rst asserted mid-instruction: aborts immediately; no write enable fires in the reset cycle; restarts at FETCH.
- Simultaneous rst and ena: rst wins.
- Outputs are combinational from registered state, cnt, op, funct and zero; there are no combinational paths from ena to the selects.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings (FETCH=0 .. JUMP=11)
  - opcode and funct constants
  - alucontrol codes
  - alusrcb and pcsrc encodings
- One sub-module: alu_decoder, which maps (aluop[1:0], funct) to alucontrol plus a funct_valid flag; it is instantiated once.

Test Plan:
- MEM_LAT=1, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses in cycle 5; irwrite only in cycle 1.
- MEM_LAT=3, op=101011 -> FETCH lasts 3 cycles, irwrite only on its 3rd; MEMWR lasts 3 cycles, memwrite only on its 3rd; total 8 cycles.
- op=000100 in BEQ: zero=1 -> pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0.
- R-type sweep over funct 100000/100010/100100/100101/101010 -> alucontrol 010/110/000/001/111 in EXECUTE; funct=000111 -> illegal pulse, return to FETCH, regwrite never asserts.
- ena=0 for 5 cycles during MEMRD with MEM_LAT=2 -> state holds and all enables are 0; after ena returns, the remaining latency is unchanged.
- rst pulsed during ALUWB -> regwrite=0 in that cycle, state=0 the next cycle, then a normal fetch.
